// File: rtl/mux_8x1_rr_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : mux_8x1_rr_arbiter                                            |
// | Purpose  : Round-robin arbiter granting one 8:1 mux datapath to 8 users. |
// | Option   : MUX_ARB_BURST_LIMIT_EN caps a tenure at MAX_BEATS cycles.     |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module mux_8x1_rr_arbiter #(
  parameter int MAX_BEATS = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req_i,
  input  logic       done_i,
  output logic [7:0] gnt_o,
  output logic       gnt_valid_o,
  output logic [2:0] sel_o
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] gnt_q, gnt_d;
  logic       gnt_valid_q, gnt_valid_d;
  logic [2:0] sel_q, sel_d;
  logic [2:0] ptr_q, ptr_d;

  logic       win_found;
  logic [2:0] win_idx;
  logic       beat_limit;

  // Rotating priority search: first requester at or above ptr, modulo 8.
  always_comb begin
    win_found = 1'b0;
    win_idx   = ptr_q;
    for (int k = 0; k < 8; k++) begin
      if (!win_found && req_i[3'(ptr_q + 3'(k))]) begin
        win_found = 1'b1;
        win_idx   = 3'(ptr_q + 3'(k));
      end
    end
  end

`ifdef MUX_ARB_BURST_LIMIT_EN
  logic [7:0] beat_q, beat_d;

  always_comb begin
    beat_d = beat_q;
    if (state_q == IDLE) begin
      beat_d = 8'd0;
    end else begin
      beat_d = beat_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      beat_q <= 8'd0;
    end else begin
      beat_q <= beat_d;
    end
  end

  assign beat_limit = (beat_q == 8'(MAX_BEATS - 1));
`else
  logic [7:0] unused_max_beats;
  assign unused_max_beats = 8'(MAX_BEATS);
  assign beat_limit       = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    gnt_valid_d = gnt_valid_q;
    sel_d       = sel_q;
    ptr_d       = ptr_q;
    case (state_q)
      IDLE: begin
        gnt_d       = 8'h00;
        gnt_valid_d = 1'b0;
        if (win_found) begin
          state_d     = GRANT;
          gnt_d       = 8'(1) << win_idx;
          gnt_valid_d = 1'b1;
          sel_d       = win_idx;
          ptr_d       = 3'(win_idx + 3'd1);
        end
      end
      GRANT: begin
        // sel_q holds the grantee index for the whole tenure.
        if (done_i || !req_i[sel_q] || beat_limit) begin
          state_d     = IDLE;
          gnt_d       = 8'h00;
          gnt_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = IDLE;
        gnt_d       = 8'h00;
        gnt_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      gnt_q       <= 8'h00;
      gnt_valid_q <= 1'b0;
      sel_q       <= 3'd0;
      ptr_q       <= 3'd0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      gnt_valid_q <= gnt_valid_d;
      sel_q       <= sel_d;
      ptr_q       <= ptr_d;
    end
  end

  assign gnt_o       = gnt_q;
  assign gnt_valid_o = gnt_valid_q;
  assign sel_o       = sel_q;

endmodule
`default_nettype wire
